imul1_mul_unit: RTL and testbench



---
 rtl/imul1_mul_unit_pkg.sv | 19 +
 rtl/imul1_array.sv | 46 ++++
 rtl/imul1_reg.sv | 28 ++
 rtl/ripple_adder.sv | 31 +++
 rtl/imul1_mul_unit.sv | 60 ++++++
 tb/tb_imul1_mul_unit.sv | 160 ++++++++++++++++
 6 files changed

// File: rtl/imul1_mul_unit_pkg.sv
// imul1_mul_unit_pkg
// Shared definitions for the MiniAlu multiplier: default operand width, the
// nibble width used by the IMUL1_4 opcode, and the multiply opcodes that the
// ALU decoder turns into iMode4 / iEnable for imul1_mul_unit.
package imul1_mul_unit_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int NIBBLE_W      = 4;

    // IMUL1_4  : nibble product, combinational result only
    // IMUL1_16 : full-width product, combinational result only
    // SMUL     : full-width product captured into RL/RH
    typedef enum logic [1:0] {
        OP_IMUL1_4  = 2'd0,
        OP_IMUL1_16 = 2'd1,
        OP_SMUL     = 2'd2
    } mulOpcode_t;

endpackage

// File: rtl/imul1_array.sv
// imul1_array
// Combinational unsigned N x N -> 2N shift-and-add array multiplier.
// Row i's partial product is iA gated by iB[i]. Each row is added to the
// upper N bits of the previous running sum; the low bit of every running
// sum is final and is retired as product bit i.
// Ports:
//   iA, iB    : N-bit unsigned operands
//   oProduct  : 2N-bit unsigned product
module imul1_array #(
    parameter int N = 16
) (
    input  logic [N-1:0]   iA,
    input  logic [N-1:0]   iB,
    output logic [2*N-1:0] oProduct
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : gRow
            logic [N-1:0] partial;
            logic [N:0]   sum;

            assign partial = iA & {N{iB[i]}};

            if (i == 0) begin : gFirst
                assign sum = {1'b0, partial};
            end else begin : gAdd
                ripple_adder #(.N(N)) uAdd (
                    .iA     (gRow[i-1].sum[N:1]),
                    .iB     (partial),
                    .iCarry (1'b0),
                    .oSum   (sum[N-1:0]),
                    .oCarry (sum[N])
                );
            end

            if (i < N - 1) begin : gRetire
                assign oProduct[i] = sum[0];
            end
        end
    endgenerate

    // Last row supplies {carry, sum}, i.e. product bits [2N-1:N-1].
    assign oProduct[2*N-1:N-1] = gRow[N-1].sum;

endmodule

// File: rtl/imul1_reg.sv
// imul1_reg
// Generic positive-edge register with load enable and synchronous
// active-high reset (reset wins over enable).
// Ports:
//   Clock   : rising-edge clock
//   Reset   : synchronous clear
//   iEnable : load iD at the next edge
//   iD      : data in
//   oQ      : registered data
module imul1_reg #(
    parameter int W = 32
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         iEnable,
    input  logic [W-1:0] iD,
    output logic [W-1:0] oQ
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oQ <= '0;
        end else if (iEnable) begin
            oQ <= iD;
        end
    end

endmodule

// File: rtl/ripple_adder.sv
// ripple_adder
// N-bit ripple-carry adder built as a chain of full adders.
// Ports:
//   iA, iB  : N-bit addends
//   iCarry  : carry-in
//   oSum    : N-bit sum
//   oCarry  : carry-out
module ripple_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] iA,
    input  logic [N-1:0] iB,
    input  logic         iCarry,
    output logic [N-1:0] oSum,
    output logic         oCarry
);

    // The carry is a procedural variable so the chain stays one process
    // instead of a self-referencing carry vector.
    always_comb begin
        logic carry;
        carry = iCarry;
        oSum  = '0;
        for (int k = 0; k < N; k++) begin
            oSum[k] = iA[k] ^ iB[k] ^ carry;
            carry   = (iA[k] & iB[k]) | (carry & (iA[k] ^ iB[k]));
        end
        oCarry = carry;
    end

endmodule

// File: rtl/imul1_mul_unit.sv
// imul1_mul_unit
// MiniAlu unsigned multiplier. Drives the selected product combinationally
// for RAM write-back and optionally captures it into the RL/RH pair.
// Ports:
//   Clock   : rising-edge clock
//   Reset   : synchronous active-high, clears RL/RH
//   iA, iB  : WIDTH-bit unsigned operands
//   iMode4  : 1 = product of iA[3:0] x iB[3:0], 0 = full-width product
//   iEnable : load the selected product into RL/RH at the next edge
//   oResult : combinational selected product (2*WIDTH bits)
//   oRL     : low half of the last loaded product
//   oRH     : high half of the last loaded product
module imul1_mul_unit
    import imul1_mul_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    input  logic               iMode4,
    input  logic               iEnable,
    output logic [2*WIDTH-1:0] oResult,
    output logic [WIDTH-1:0]   oRL,
    output logic [WIDTH-1:0]   oRH
);

    logic [2*WIDTH-1:0]    wideProduct;
    logic [2*NIBBLE_W-1:0] nibbleProduct;
    logic [2*WIDTH-1:0]    resultQ;

    imul1_array #(.N(WIDTH)) uWideArray (
        .iA       (iA),
        .iB       (iB),
        .oProduct (wideProduct)
    );

    // Separate small array so nibble mode is short-path, not a masked wide product.
    imul1_array #(.N(NIBBLE_W)) uNibbleArray (
        .iA       (iA[NIBBLE_W-1:0]),
        .iB       (iB[NIBBLE_W-1:0]),
        .oProduct (nibbleProduct)
    );

    assign oResult = iMode4 ? {{(2*WIDTH-2*NIBBLE_W){1'b0}}, nibbleProduct}
                            : wideProduct;

    imul1_reg #(.W(2*WIDTH)) uResultReg (
        .Clock   (Clock),
        .Reset   (Reset),
        .iEnable (iEnable),
        .iD      (oResult),
        .oQ      (resultQ)
    );

    assign oRL = resultQ[WIDTH-1:0];
    assign oRH = resultQ[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_imul1_mul_unit.sv
module tb_imul1_mul_unit;

    localparam int W = 16;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [W-1:0]   iA;
    logic [W-1:0]   iB;
    logic           iMode4;
    logic           iEnable;
    logic [2*W-1:0] oResult;
    logic [W-1:0]   oRL;
    logic [W-1:0]   oRH;

    imul1_mul_unit #(.WIDTH(W)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .iA      (iA),
        .iB      (iB),
        .iMode4  (iMode4),
        .iEnable (iEnable),
        .oResult (oResult),
        .oRL     (oRL),
        .oRH     (oRH)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string          name;
        bit             isReg;
        logic [2*W-1:0] expected;
    } checkItem_t;

    checkItem_t     scoreQ[$];
    int             total = 0;
    int             bad = 0;
    logic [2*W-1:0] regModel = '0;
    bit             stimDone = 1'b0;

    // Monitor: every falling edge, check whatever the stimulus side queued
    // for the current cycle against the DUT outputs.
    always @(negedge Clock) begin
        while (scoreQ.size() > 0) begin
            checkItem_t e;
            logic [2*W-1:0] actual;
            e = scoreQ.pop_front();
            actual = e.isReg ? {oRH, oRL} : oResult;
            total++;
            if (actual !== e.expected) begin
                bad++;
                $display("FAIL %s%s: got %h, want %h", e.name,
                         e.isReg ? ".regs" : ".result", actual, e.expected);
            end
        end
    end

    // Apply one cycle of stimulus, queue the expected combinational result and
    // the register contents expected during this cycle, then advance the model.
    task automatic applyVec(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic m4, input logic en, input logic rst,
                            input logic [2*W-1:0] expResult, input string name);
        checkItem_t r;
        checkItem_t g;
        iA = a; iB = b; iMode4 = m4; iEnable = en; Reset = rst;
        r.name = name; r.isReg = 1'b0; r.expected = expResult;
        g.name = name; g.isReg = 1'b1; g.expected = regModel;
        scoreQ.push_back(r);
        scoreQ.push_back(g);
        @(posedge Clock);
        if (rst)     regModel = '0;
        else if (en) regModel = expResult;
        #1;
    endtask

    initial begin
        iA = '0; iB = '0; iMode4 = 1'b0; iEnable = 1'b0; Reset = 1'b1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        regModel = '0;

        // Reset state: registers cleared, zero product
        applyVec(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, "reset_state");

        // Basic
        applyVec(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 32'h0000_000F, "basic_3x5");
        applyVec(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, "after_basic");

        // Extremes
        applyVec(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 32'hFFFE_0001, "max_x_max");
        applyVec(16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 32'h0000_0000, "zero_x_beef");
        applyVec(16'h8000, 16'h0002, 1'b0, 1'b0, 1'b0, 32'h0001_0000, "msb_carry");
        applyVec(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 32'h0000_FFFF, "max_x_one");
        applyVec(16'h00FF, 16'h0100, 1'b0, 1'b0, 1'b0, 32'h0000_FF00, "ff_x_100");

        // Nibble mode: upper operand bits ignored, zero-extended 8-bit product
        applyVec(16'h012F, 16'hABCF, 1'b1, 1'b1, 1'b0, 32'h0000_00E1, "nib_f_x_f");
        applyVec(16'h0007, 16'h0009, 1'b1, 1'b0, 1'b0, 32'h0000_003F, "nib_7_x_9");
        applyVec(16'h00F0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, "nib_zero_lo");

        // Hold: load then change operands with enable low
        applyVec(16'h1234, 16'h0010, 1'b0, 1'b1, 1'b0, 32'h0001_2340, "hold_load");
        applyVec(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE_0001, "hold_1");
        applyVec(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 32'h0000_000F, "hold_2");
        applyVec(16'h0007, 16'h0009, 1'b1, 1'b0, 1'b0, 32'h0000_003F, "hold_3");

        // Reset priority over enable; oResult unaffected by reset
        applyVec(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, 32'h0000_000F, "rst_with_en");
        applyVec(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h0000_0006, "after_rst");

        // Back-to-back loads
        applyVec(16'h0002, 16'h0003, 1'b0, 1'b1, 1'b0, 32'h0000_0006, "b2b_1");
        applyVec(16'h1000, 16'h1000, 1'b0, 1'b1, 1'b0, 32'h0100_0000, "b2b_2");
        applyVec(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, "b2b_end");

        // Every nibble pair, with random upper bits
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [W-1:0] a;
                logic [W-1:0] b;
                logic [2*W-1:0] p;
                a = {$urandom_range(0, 4095), 4'(i)};
                b = {$urandom_range(0, 4095), 4'(j)};
                p = 32'(i * j);
                applyVec(a, b, 1'b1, (((i + j) % 3) == 0), 1'b0, p, "nib_exh");
            end
        end

        // Random full-width pairs against a reference product
        for (int n = 0; n < 10000; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [2*W-1:0] p;
            a = 16'($urandom);
            b = 16'($urandom);
            p = 32'(a) * 32'(b);
            applyVec(a, b, 1'b0, ((n % 7) == 0), 1'b0, p, "rand");
        end

        @(negedge Clock);
        #1;
        if (scoreQ.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d pending, want 0", scoreQ.size());
        end
        stimDone = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        if (!stimDone) begin
            $display("FAIL timeout: got no completion, want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
